// File: rtl/turret_scan_ctrl_if.sv
// Host readout bundle of the turret scan controller: live position, published frame and pair read port.
// frame_valid/frame_ack: frame_valid rises when a frame is published and stays high until a frame_ack pulse is seen.
interface turret_scan_ctrl_if #(
    parameter int POS_W       = 16,
    parameter int MAX_BEACONS = 4
);
    localparam int CNT_W = $clog2(MAX_BEACONS + 1);
    localparam int IDX_W = (MAX_BEACONS > 1) ? $clog2(MAX_BEACONS) : 1;

    logic [POS_W-1:0]   position;
    logic               frame_valid;
    logic               frame_ack;
    logic [CNT_W-1:0]   beacon_cnt;
    logic               overflow;
    logic [IDX_W-1:0]   rd_idx;
    logic [2*POS_W-1:0] rd_data;
    logic               stalled;

    modport slave (
        output position, frame_valid, beacon_cnt, overflow, rd_data, stalled,
        input  frame_ack, rd_idx
    );

    modport master (
        input  position, frame_valid, beacon_cnt, overflow, rd_data, stalled,
        output frame_ack, rd_idx
    );
endinterface

// File: rtl/turret_scan_ctrl.sv
// Turret beacon scan sequencer: encoder tracking, opto-framed revolutions, beam pair capture and frame publish.
// Optional stall detector enabled by defining TURRET_STALL_EN.
module turret_scan_ctrl #(
    parameter int POS_W       = 16,
    parameter int MAX_BEACONS = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                opto,
    input  logic                code_a,
    input  logic                code_b,
    input  logic                laser,
    turret_scan_ctrl_if.slave   host,
    output logic [1:0]          dbg_state
);
    localparam int CNT_W  = $clog2(MAX_BEACONS + 1);
    localparam int IDX_W  = (MAX_BEACONS > 1) ? $clog2(MAX_BEACONS) : 1;
    localparam int PAIR_W = 2 * POS_W;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEACONS);

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, SCAN = 2'd2, PUBLISH = 2'd3} state_e;

    state_e state_q, state_d;
    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [2:0]        prev_q, prev_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [POS_W-1:0]  start_q, start_d;
    logic              in_beam_q, in_beam_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic              wovf_q, wovf_d;
    logic [PAIR_W-1:0] work_q [MAX_BEACONS];
    logic [PAIR_W-1:0] work_d [MAX_BEACONS];
    logic [PAIR_W-1:0] shadow_q [MAX_BEACONS];
    logic [PAIR_W-1:0] shadow_d [MAX_BEACONS];
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;
    logic              ovf_q, ovf_d;
    logic              fv_q, fv_d;

    logic [3:0] pins_s;
    logic opto_s, a_s, b_s, laser_s;
    logic opto_rise, a_rise, laser_rise, laser_fall;

    // Pin order through the chain: {laser, code_b, code_a, opto}.
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], {laser, code_b, code_a, opto}};
    assign pins_s  = sync_q[SYNC_STAGES-1];
    assign opto_s  = pins_s[0];
    assign a_s     = pins_s[1];
    assign b_s     = pins_s[2];
    assign laser_s = pins_s[3];
    assign prev_d  = {laser_s, a_s, opto_s};

    assign opto_rise  = opto_s & ~prev_q[0];
    assign a_rise     = a_s & ~prev_q[1];
    assign laser_rise = laser_s & ~prev_q[2];
    assign laser_fall = ~laser_s & prev_q[2];

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        start_d   = start_q;
        in_beam_d = in_beam_q;
        wcnt_d    = wcnt_q;
        wovf_d    = wovf_q;
        work_d    = work_q;
        shadow_d  = shadow_q;
        bcnt_d    = bcnt_q;
        ovf_d     = ovf_q;
        fv_d      = fv_q;

        // Index wins over a coincident A rise, which is dropped.
        if (opto_rise) begin
            pos_d = '0;
        end else if (a_rise) begin
            pos_d = b_s ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
        end

        if (host.frame_ack) begin
            fv_d = 1'b0;
        end
        if (state_q == PUBLISH) begin
            shadow_d = work_q;
            bcnt_d   = wcnt_q;
            ovf_d    = wovf_q;
            fv_d     = 1'b1;
        end

        if (!enable) begin
            state_d   = IDLE;
            work_d    = '{default: '0};
            wcnt_d    = '0;
            wovf_d    = 1'b0;
            in_beam_d = 1'b0;
            start_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (opto_rise) begin
                        state_d   = SCAN;
                        work_d    = '{default: '0};
                        wcnt_d    = '0;
                        wovf_d    = 1'b0;
                        in_beam_d = 1'b0;
                        start_d   = '0;
                    end
                end
                SCAN: begin
                    // Uses pos_q, so a fall on the index cycle keeps the pre-reset position.
                    if (laser_fall && in_beam_q) begin
                        if (wcnt_q < MAX_CNT) begin
                            work_d[IDX_W'(wcnt_q)] = {start_q, pos_q};
                            wcnt_d = wcnt_q + CNT_W'(1);
                        end else begin
                            wovf_d = 1'b1;
                        end
                        in_beam_d = 1'b0;
                    end
                    if (laser_rise) begin
                        start_d   = pos_q;
                        in_beam_d = 1'b1;
                    end
                    if (opto_rise) begin
                        in_beam_d = 1'b0;
                        state_d   = PUBLISH;
                    end
                end
                PUBLISH: begin
                    work_d    = '{default: '0};
                    wcnt_d    = '0;
                    wovf_d    = 1'b0;
                    in_beam_d = 1'b0;
                    start_d   = '0;
                    if (laser_rise) begin
                        start_d   = pos_q;
                        in_beam_d = 1'b1;
                    end
                    state_d = SCAN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            prev_q    <= '0;
            pos_q     <= '0;
            start_q   <= '0;
            in_beam_q <= 1'b0;
            wcnt_q    <= '0;
            wovf_q    <= 1'b0;
            work_q    <= '{default: '0};
            shadow_q  <= '{default: '0};
            bcnt_q    <= '0;
            ovf_q     <= 1'b0;
            fv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            pos_q     <= pos_d;
            start_q   <= start_d;
            in_beam_q <= in_beam_d;
            wcnt_q    <= wcnt_d;
            wovf_q    <= wovf_d;
            work_q    <= work_d;
            shadow_q  <= shadow_d;
            bcnt_q    <= bcnt_d;
            ovf_q     <= ovf_d;
            fv_q      <= fv_d;
        end
    end

`ifdef TURRET_STALL_EN
    localparam int ST_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ST_W-1:0] ST_MAX = ST_W'(TIMEOUT_CYC);
    logic [ST_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating counter doubles as the sticky stalled flag.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!enable || state_q == IDLE || opto_rise) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != ST_MAX) begin
            stall_cnt_d = stall_cnt_q + ST_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign host.stalled = (stall_cnt_q == ST_MAX);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign host.stalled   = 1'b0;
`endif

    assign host.position    = pos_q;
    assign host.frame_valid = fv_q;
    assign host.beacon_cnt  = bcnt_q;
    assign host.overflow    = ovf_q;
    assign host.rd_data     = (CNT_W'(host.rd_idx) < bcnt_q) ? shadow_q[host.rd_idx] : '0;
    assign dbg_state        = state_q;
endmodule
